// File: rtl/sdp_rd_arbiter_pkg.sv
// sdp_arb_pkg: shared state, tag type and latency helper for the BRAM read-port arbiter
package sdp_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    typedef struct packed {
        logic       vld;
        logic [7:0] id;
    } rd_tag_t;

    function automatic int rd_lat(input int pipe_depth);
        return pipe_depth + 1;
    endfunction

endpackage

// File: rtl/sdp_rd_tag_pipe.sv
// sdp_rd_tag_pipe: shift register of read tags matching the BRAM read latency
module sdp_rd_tag_pipe
    import sdp_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int ID_W  = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t din,
    output rd_tag_t dout
);

    localparam logic [7:0] ID_MASK = 8'((1 << ID_W) - 1);

    rd_tag_t [DEPTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{vld: din.vld, id: din.id & ID_MASK};
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/sdp_rd_arbiter.sv
// sdp_rd_arbiter: round-robin, burst-locking arbiter for the shared BRAM read port
// Define SDP_RD_ARB_STATS_EN to add per-requester saturating grant counters.
module sdp_rd_arbiter
    import sdp_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          bram_enb,
    output logic [ADDR_WIDTH-1:0]         bram_addrb,
    input  logic [DATA_WIDTH-1:0]         bram_doutb
`ifdef SDP_RD_ARB_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [NUM_REQ*32-1:0]         stat_grants
`endif
);

    localparam int RD_LAT = rd_lat(PIPE_DEPTH);
    localparam int ID_W   = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int BW     = $clog2(MAX_BURST + 1);

    arb_state_e      state;
    logic [ID_W-1:0] rr_ptr, owner, hi, lo, win, gid, rr_nxt;
    logic [BW-1:0]   beats;
    logic            rel, hi_v, gnt_ok, hs, last_hs;
    rd_tag_t         tag_in, tag_out;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi   = '0;
        lo   = '0;
        hi_v = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi   = ID_W'(i);
                    hi_v = 1'b1;
                end
            end
        end
        win = hi_v ? hi : lo;
    end

    assign gid       = state == ARB_LOCK ? owner : win;
    assign gnt_ok    = rst_n && (state == ARB_IDLE ? |req_valid : !rel && req_valid[owner]);
    assign req_ready = gnt_ok ? NUM_REQ'(1) << gid : '0;
    assign hs        = |(req_valid & req_ready);
    assign last_hs   = req_last[gid];
    assign rr_nxt    = int'(gid) == NUM_REQ - 1 ? '0 : gid + 1'b1;
    assign bram_enb  = hs;
    assign bram_addrb = hs ? req_addr[gid*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign rsp_data  = bram_doutb;

    // rel marks the single dead cycle after a burst ends, so nobody is granted in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            beats  <= '0;
            rel    <= 1'b0;
        end else begin
            if (hs) rr_ptr <= rr_nxt;
            if (state == ARB_IDLE) begin
                if (hs && !last_hs && MAX_BURST > 1) begin
                    state <= ARB_LOCK;
                    owner <= gid;
                    beats <= BW'(1);
                    rel   <= 1'b0;
                end
            end else if (rel || !req_valid[owner]) begin
                state <= ARB_IDLE;
                rel   <= 1'b0;
            end else begin
                beats <= beats + 1'b1;
                rel   <= last_hs || int'(beats) + 1 >= MAX_BURST;
            end
        end
    end

    assign tag_in = '{vld: hs, id: 8'(gid)};

    sdp_rd_tag_pipe #(
        .DEPTH (RD_LAT),
        .ID_W  (ID_W)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tag_in),
        .dout  (tag_out)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign rsp_valid[g] = tag_out.vld && tag_out.id == 8'(g);
    end

`ifdef SDP_RD_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stat_clr)
                    stat_grants[i*32 +: 32] <= '0;
                else if (req_valid[i] && req_ready[i] && stat_grants[i*32 +: 32] != '1)
                    stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdp_rd_arbiter.sv
// tb_sdp_rd_arbiter: directed checks of arbitration, burst lock, latency, reset and read-before-write
module tb_sdp_rd_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_last = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [1:0]      req_ready, rsp_valid, ready3, rsp3;
    logic [DW-1:0]   rsp_data, bram_doutb, data3;
    logic            bram_enb, enb3;
    logic [AW-1:0]   bram_addrb, addrb3;
    logic            wea = 1'b0;
    logic [AW-1:0]   addra = '0;
    logic [DW-1:0]   dina = '0;
    logic [DW-1:0]   mem [1<<AW];
    logic [DW-1:0]   rd0;
    logic [1:0]      want;
    int              n_chk = 0;
    int              n_pass = 0;
`ifdef SDP_RD_ARB_STATS_EN
    logic            stat_clr = 1'b0;
    logic [63:0]     stat_grants, stat3;
`endif

    always #5 clk = ~clk;

    // Read-first BRAM with one output register: enb -> doutb takes two cycles.
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000 + i;
    always @(posedge clk) begin
        if (bram_enb) rd0 <= mem[bram_addrb];
        if (wea) mem[addra] = dina;
        bram_doutb <= rd0;
    end

    sdp_rd_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE_DEPTH(1), .MAX_BURST(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
`ifdef SDP_RD_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_grants(stat_grants)
`endif
    );

    sdp_rd_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE_DEPTH(3), .MAX_BURST(16)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr),
        .req_ready(ready3), .rsp_valid(rsp3), .rsp_data(data3),
        .bram_enb(enb3), .bram_addrb(addrb3), .bram_doutb('0)
`ifdef SDP_RD_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_grants(stat3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_chk++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #3;
        check("rst_ready", {ready3, req_ready}, 0);
        check("rst_enb", {enb3, bram_enb, addrb3, bram_addrb}, 0);
        check("rst_rsp", {rsp3, rsp_valid}, 0);
        req_valid = '0;
        rst_n = 1'b1;
        cyc();

        // alternating single beats
        req_addr = {10'd9, 10'd5};
        req_last = 2'b11;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) req_valid = '0;
            #2;
            want = i[0] ? 2'b10 : 2'b01;
            if (i < 4) begin
                check("alt_ready", req_ready, want);
                check("alt_addr", bram_addrb, i[0] ? 9 : 5);
            end else begin
                check("alt_idle", {bram_enb, req_ready}, 0);
            end
            check("alt_rsp", rsp_valid, i < 2 ? 2'b00 : want);
            if (i >= 2) check("alt_data", rsp_data, i[0] ? 32'h1009 : 32'h1005);
            cyc();
        end

        // 4-beat burst from req0, then release cycle, then req1
        req_valid = 2'b11;
        req_last = 2'b10;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) req_last = 2'b11;
            if (i == 4) req_last = 2'b10;
            if (i == 6) req_valid = '0;
            #2;
            check("burst_ready", req_ready, i < 4 ? 2'b01 : i == 5 ? 2'b10 : 2'b00);
            cyc();
        end

        // endless burst capped at MAX_BURST
        req_valid = 2'b11;
        req_last = 2'b10;
        for (int i = 0; i < 18; i++) begin
            #2;
            check("maxb_ready", req_ready, i < 16 ? 2'b01 : i == 16 ? 2'b00 : 2'b10);
            cyc();
        end
        req_valid = '0;
        repeat (6) cyc();

        // reset with reads in flight
        req_last = 2'b11;
        req_valid = 2'b01;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check("arst_ready", {ready3, req_ready}, 0);
        check("arst_bram", {enb3, bram_enb, addrb3, bram_addrb}, 0);
        check("arst_rsp", {rsp3, rsp_valid}, 0);
        req_valid = '0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            check("post_rst_rsp", {rsp3, rsp_valid}, 0);
            check("post_rst_data3", data3, 0);
            cyc();
        end

        // same-cycle write and read of address 7
        req_addr = {10'd9, 10'd7};
        req_valid = 2'b01;
        wea = 1'b1;
        addra = 10'd7;
        dina = 32'h0000A5A5;
        cyc();
        wea = 1'b0;
        cyc();
        req_valid = '0;
        #2;
        check("rw_old", {rsp_valid, rsp_data}, {2'b01, 32'h00001007});
        cyc();
        #2;
        check("rw_new", {rsp_valid, rsp_data}, {2'b01, 32'h0000A5A5});
        cyc();

`ifdef SDP_RD_ARB_STATS_EN
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        req_valid = 2'b10;
        repeat (10) cyc();
        req_valid = '0;
        #2;
        check("stat_req1", stat_grants[63:32], 10);
        check("stat_req0", stat_grants[31:0], 0);
        check("stat3_req1", stat3[63:32], 10);
        req_valid = 2'b10;
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        req_valid = '0;
        #2;
        check("stat_clr", stat_grants[63:32], 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
